data_sram_responder: RTL

- Responder end of the CPU data-SRAM interface; the CPU's load/store path is the initiator.
- Accepts en/wen/addr/wdata requests and performs byte-lane-masked word writes and word reads.
- Returns read data on data_sram_rdata, which the MEM stage consumes.
- Models configurable access latency; for LATENCY>1 it raises stallreq into the CPU stall controller until the access completes.

---
 rtl/data_sram_responder_pkg.sv | 18 +
 rtl/data_sram_array.sv | 42 ++++
 rtl/data_sram_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared constants for the data-SRAM responder: FSM encoding and lane geometry.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package data_sram_responder_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Largest access latency the counter and FSM are built for
  localparam int LATENCY_MAX = 15;

  // Byte-lane geometry of a 32-bit word
  localparam int BYTE_W = 8;
  localparam int LANES  = 4;

endpackage

// File: rtl/data_sram_array.sv
// Word storage with per-byte-lane synchronous writes and a registered read port.
// Latency: read data registered one cycle after an enabled read access.
// Backpressure: none; every enabled access is performed on the clock edge it is presented.
module data_sram_array
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_en,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  // Byte-lane masked write; storage contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (acc_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wen[i]) begin
          mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read register only loads on a read, so it holds across writes and idle cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= 32'h0;
    end else if (acc_en && (wen == 4'b0000)) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Responder for the CPU data-SRAM bus: byte-masked word writes and word reads.
// Latency: LATENCY cycles; read data lands one cycle after single-cycle accesses.
// Backpressure: stallreq held for LATENCY-1 cycles per access, then one dead cycle.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq
);

  // The request cycle itself is the first stall cycle, so BUSY lasts LATENCY-2
  // cycles. With LATENCY==2 there is no BUSY and the access completes on the
  // request edge, keeping the total stall at LATENCY-1 for every latency.
  localparam bit             MULTI    = (LATENCY > 1);
  localparam bit             NO_BUSY  = (LATENCY <= 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 2) ? (LATENCY - 2) : 0);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic [ADDR_W-1:0] bus_word;
  logic              req_here;
  logic              busy_last;
  logic              acc_en;
  logic [3:0]        acc_wen;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              unused_addr_bits;

  assign bus_word         = data_sram_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  // Request acceptance and access strobe; rst gates both so a pending write is dropped
  always_comb begin
    req_here  = !rst && (state == ST_IDLE) && data_sram_en;
    busy_last = !rst && (state == ST_BUSY) && (cnt == CNT_W'(1));
    acc_en    = (req_here && NO_BUSY) || busy_last;
    stallreq  = !rst && ((state == ST_BUSY) || (MULTI && req_here));
  end

  // Live bus drives the array when idle; the latched request drives it from BUSY
  always_comb begin
    acc_wen   = data_sram_wen;
    acc_addr  = bus_word;
    acc_wdata = data_sram_wdata;
    if (state == ST_BUSY) begin
      acc_wen   = req_wen;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  // FSM, latency counter and request latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_wen   <= 4'b0000;
      req_addr  <= '0;
      req_wdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (data_sram_en && MULTI) begin
            req_wen   <= data_sram_wen;
            req_addr  <= bus_word;
            req_wdata <= data_sram_wdata;
            if (NO_BUSY) begin
              state <= ST_DONE;
            end else begin
              cnt   <= CNT_LOAD;
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (cnt == CNT_W'(1)) begin
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // The bus still shows the serviced request here, so en is not sampled
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  data_sram_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .acc_en(acc_en),
    .wen   (acc_wen),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .rdata (data_sram_rdata)
  );

endmodule
